// File: rtl/data_mem_responder_if.sv
// Request/response bus between the control stage (master) and the data memory (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory: byte-lane merging on stores, zero-extended lane
// extraction on loads, one response pulse a fixed number of cycles after accept.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_err_c;
  logic            mem_we_c;
  logic [3:0]      byte_en_c;
  logic [31:0]     wdata_rep_c;
  logic [31:0]     rd_word_c;
  logic [31:0]     load_data_c;

  // Classify an incoming request: illegal size, misalignment or beyond the array.
  always_comb begin
    req_err_c = 1'b0;
    case (bus.req_size)
      2'b00:   req_err_c = 1'b0;
      2'b01:   req_err_c = bus.req_addr[0];
      2'b10:   req_err_c = |bus.req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
    if ((bus.req_addr[31:2] >> AW) != '0) req_err_c = 1'b1;
  end

  // Lane steering: replicate store data across lanes and select byte enables; extract load lane.
  always_comb begin
    rd_word_c   = mem[idx_q];
    byte_en_c   = 4'b1111;
    wdata_rep_c = wdata_q;
    load_data_c = rd_word_c;
    case (size_q)
      2'b00: begin
        byte_en_c   = 4'b0001 << lane_q;
        wdata_rep_c = {4{wdata_q[7:0]}};
        load_data_c = {24'b0, rd_word_c[{lane_q, 3'b000} +: 8]};
      end
      2'b01: begin
        byte_en_c   = lane_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{wdata_q[15:0]}};
        load_data_c = {16'b0, rd_word_c[{lane_q[1], 4'b0000} +: 16]};
      end
      default: begin
        byte_en_c   = 4'b1111;
        wdata_rep_c = wdata_q;
        load_data_c = rd_word_c;
      end
    endcase
  end

  // The single array access happens on the edge where the latency counter has expired.
  assign mem_we_c = (state_q == S_ACCESS) && (cnt_q == '0) && !err_q && we_q;

  // Byte-enabled store into the array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_c[b]) mem[idx_q][8*b +: 8] <= wdata_rep_c[8*b +: 8];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          idx_d   = bus.req_addr[AW+1:2];
          lane_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          err_d   = req_err_c;
          cnt_d   = CW'(READ_LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (!err_q && !we_q) ? load_data_c : 32'h0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
